ram_fifo_ctrl: RTL

Single-clock FIFO controller that owns the port of the 32x32 single-port `ram` block and turns it into a 32-entry queue with valid/ready push and pop interfaces. It sits directly upstream of `ram`: it drives `cen/wen/addr/din` and consumes `dout`. It adds a one-entry output register so that pop-side back-pressure never stalls the RAM port.

---
 rtl/ram_pkg.sv | 17 +
 rtl/fifo_out_reg.sv | 42 ++++
 rtl/ram_fifo_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// ram_pkg: widths and the RAM port bundle shared by the 32x32 single-port
// ram, its FIFO controller (ram_fifo_ctrl) and their benches.
package ram_pkg;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2 ** AW;

  // RAM word count at which the storage is full (count register is AW+1 bits)
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  typedef struct packed {
    logic          cen;
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
  } ram_req_t;
endpackage

// File: rtl/fifo_out_reg.sv
// fifo_out_reg: one-entry valid/ready output register with a load port.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   clr             synchronous flush (drops the held word)
//   load, load_data write a new word into the register
//   out_ready       downstream accepts the held word
//   out_valid       register holds a word
//   out_data        held word (stable while out_valid && !out_ready)
//   slot_free       register is empty or is being popped this cycle
module fifo_out_reg #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          slot_free
);

  assign slot_free = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (clr) begin
      out_valid <= 1'b0;
    end else if (load) begin
      // A load only arrives after the slot was freed, so it never overwrites
      // an unconsumed word.
      out_valid <= 1'b1;
      out_data  <= load_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: turns the 32x32 single-port ram into a 32-entry queue with
// valid/ready push and pop sides, plus a one-entry output register.
// Ports:
//   clk, rst_n, clr                 clock, async reset, synchronous flush
//   in_valid, in_ready, in_data     push interface
//   out_valid, out_ready, out_data  pop interface
//   level, full, empty              occupancy status
//   ram_cen, ram_wen, ram_addr,
//   ram_din, ram_dout               RAM port (dout registered by the ram)
module ram_fifo_ctrl
  import ram_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty,
  output logic          ram_cen,
  output logic          ram_wen,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          rd_pend;
  logic          slot_free;
  logic          rd_issue;
  logic          wr_fire;
  ram_req_t      req;

  // Reads take priority on the single port; a write only goes through on a
  // cycle with no read issue.
  assign rd_issue = (cnt != '0) && !rd_pend && slot_free && !clr;
  assign in_ready = (cnt != CNT_FULL) && !rd_issue && !clr;
  assign wr_fire  = in_valid && in_ready;

  always_comb begin
    req = '0;
    if (rd_issue) begin
      req.cen  = 1'b1;
      req.addr = rd_ptr;
    end else if (wr_fire) begin
      req.cen  = 1'b1;
      req.wen  = 1'b1;
      req.addr = wr_ptr;
      req.din  = in_data;
    end
  end

  assign ram_cen  = req.cen;
  assign ram_wen  = req.wen;
  assign ram_addr = req.addr;
  assign ram_din  = req.din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      rd_pend <= 1'b0;
    end else if (clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      rd_pend <= 1'b0;
    end else begin
      if (rd_issue) rd_ptr <= rd_ptr + 1'b1;
      if (wr_fire)  wr_ptr <= wr_ptr + 1'b1;
      // rd_issue and wr_fire are mutually exclusive
      if (wr_fire)       cnt <= cnt + 1'b1;
      else if (rd_issue) cnt <= cnt - 1'b1;
      // rd_issue is blocked while rd_pend is set, so this also clears it
      rd_pend <= rd_issue;
    end
  end

  fifo_out_reg #(.DW(DW)) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .load      (rd_pend),
    .load_data (ram_dout),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .slot_free (slot_free)
  );

  assign level = cnt + (AW + 1)'(rd_pend) + (AW + 1)'(out_valid);
  assign full  = (cnt == CNT_FULL);
  assign empty = (level == '0);

endmodule
